// File: rtl/burst_master_port_if.sv
// Signal bundle between the burst master port, its master core and the serial bus/arbiter.
// The master modport is the port's view; the slave modport is the environment's view.
interface burst_master_port_if #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDRESS_LEN = 12,
  parameter int WORD_SIZE   = 8,
  parameter int BURST_SIZE  = 12,
  parameter int LANES       = 2
);
  // Core side
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             instruction;
  logic [SLAVE_LEN-1:0]   slave_select;
  logic [ADDRESS_LEN-1:0] address;
  logic [BURST_SIZE-1:0]  burst_num;
  logic [WORD_SIZE-1:0]   data_out;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [WORD_SIZE-1:0]   data_in;
  logic                   new_rx;
  logic                   tx_done;
  logic                   rx_done;
  logic                   trans_done;
  logic                   error;
  // Bus / arbiter side
  logic [LANES-1:0]       tx_header;
  logic [LANES-1:0]       tx_data;
  logic [LANES-1:0]       rx_data;
  logic                   master_valid;
  logic                   slave_ready;
  logic                   slave_valid;
  logic                   master_ready;
  logic                   write_en;
  logic                   read_en;
  logic                   approval_request;
  logic                   approval_grant;
  logic                   bus_busy;

  modport master (
    input  cmd_valid, instruction, slave_select, address, burst_num, data_out, wr_valid,
           rx_data, slave_ready, slave_valid, approval_grant, bus_busy,
    output cmd_ready, wr_ready, data_in, new_rx, tx_done, rx_done, trans_done, error,
           tx_header, tx_data, master_valid, master_ready, write_en, read_en, approval_request
  );

  modport slave (
    output cmd_valid, instruction, slave_select, address, burst_num, data_out, wr_valid,
           rx_data, slave_ready, slave_valid, approval_grant, bus_busy,
    input  cmd_ready, wr_ready, data_in, new_rx, tx_done, rx_done, trans_done, error,
           tx_header, tx_data, master_valid, master_ready, write_en, read_en, approval_request
  );
endinterface

// File: rtl/burst_master_port.sv
// Serial bus master port: arbitrate, shift out a header, then move a write or read burst
// over LANES-bit serial lanes. Handshakes: a beat/word moves on a cycle where valid & ready.
module burst_master_port #(
  parameter int SLAVE_LEN     = 2,
  parameter int ADDRESS_LEN   = 12,
  parameter int WORD_SIZE     = 8,
  parameter int BURST_SIZE    = 12,
  parameter int LANES         = 2,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  burst_master_port_if.master  bus,
  output logic [2:0]           state_dbg
);
  localparam int HDR_LEN    = SLAVE_LEN + ADDRESS_LEN + BURST_SIZE;
  localparam int HDR_BEATS  = (HDR_LEN + LANES - 1) / LANES;
  localparam int HDR_BITS   = HDR_BEATS * LANES;
  localparam int WORD_BEATS = WORD_SIZE / LANES;
  localparam int MAX_BEATS  = (HDR_BEATS > WORD_BEATS) ? HDR_BEATS : WORD_BEATS;
  localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam int TMO_W      = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] HDR_LAST  = BEAT_W'(HDR_BEATS - 1);
  localparam logic [BEAT_W-1:0] WORD_LAST = BEAT_W'(WORD_BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(GRANT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_HEADER, S_WLOAD, S_WDATA, S_RDATA, S_DONE
  } state_t;

  state_t                state, state_next;
  logic                  is_read;
  logic [HDR_BITS-1:0]   hdr_sr;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BURST_SIZE-1:0] burst_len, word_cnt;
  logic [WORD_SIZE-1:0]  wr_sr, rd_sr, data_in_r;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  new_rx_r, error_r;

  logic                  accept, granted, timed_out, hdr_last, word_last, final_word;
  logic [WORD_SIZE-1:0]  rd_word;

  assign accept     = bus.cmd_valid && bus.instruction[1];
  assign granted    = bus.approval_grant && !bus.bus_busy;
  assign timed_out  = (tmo_cnt == TMO_LAST);
  assign hdr_last   = (beat_cnt == HDR_LAST);
  assign word_last  = (beat_cnt == WORD_LAST);
  // word_cnt < burst_len whenever a word is in flight, so the increment cannot wrap
  assign final_word = ((word_cnt + BURST_SIZE'(1)) == burst_len);
  assign rd_word    = {bus.rx_data, rd_sr[WORD_SIZE-1:LANES]};
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next           = state;
    bus.cmd_ready        = 1'b0;
    bus.approval_request = 1'b0;
    bus.master_valid     = 1'b0;
    bus.master_ready     = 1'b0;
    bus.wr_ready         = 1'b0;
    bus.tx_header        = '0;
    bus.tx_data          = '0;
    bus.write_en         = 1'b0;
    bus.read_en          = 1'b0;
    bus.tx_done          = 1'b0;
    bus.rx_done          = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept) state_next = S_REQ;
      end
      S_REQ: begin
        bus.approval_request = 1'b1;
        if (granted)        state_next = S_HEADER;
        else if (timed_out) state_next = S_IDLE;
      end
      S_HEADER: begin
        bus.approval_request = 1'b1;
        bus.master_valid     = 1'b1;
        bus.tx_header        = hdr_sr[LANES-1:0];
        bus.write_en         = !is_read;
        bus.read_en          = is_read;
        if (bus.slave_ready && hdr_last) begin
          if (burst_len == '0) state_next = S_DONE;
          else if (is_read)    state_next = S_RDATA;
          else                 state_next = S_WLOAD;
        end
      end
      S_WLOAD: begin
        bus.approval_request = 1'b1;
        bus.wr_ready         = 1'b1;
        bus.write_en         = 1'b1;
        if (bus.wr_valid) state_next = S_WDATA;
      end
      S_WDATA: begin
        bus.approval_request = 1'b1;
        bus.master_valid     = 1'b1;
        bus.tx_data          = wr_sr[LANES-1:0];
        bus.write_en         = 1'b1;
        if (bus.slave_ready && word_last) state_next = final_word ? S_DONE : S_WLOAD;
      end
      S_RDATA: begin
        bus.approval_request = 1'b1;
        bus.master_ready     = 1'b1;
        bus.read_en          = 1'b1;
        if (bus.slave_valid && word_last && final_word) state_next = S_DONE;
      end
      S_DONE: begin
        bus.tx_done = !is_read;
        bus.rx_done = is_read;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.trans_done = bus.tx_done || bus.rx_done;
  assign bus.data_in    = data_in_r;
  assign bus.new_rx     = new_rx_r;
  assign bus.error      = error_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_read   <= 1'b0;
      hdr_sr    <= '0;
      beat_cnt  <= '0;
      burst_len <= '0;
      word_cnt  <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      data_in_r <= '0;
      tmo_cnt   <= '0;
      new_rx_r  <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      new_rx_r <= 1'b0;
      error_r  <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          is_read   <= bus.instruction[0];
          hdr_sr    <= HDR_BITS'({bus.burst_num, bus.address, bus.slave_select});
          burst_len <= bus.burst_num;
          beat_cnt  <= '0;
          word_cnt  <= '0;
          tmo_cnt   <= '0;
        end
        S_REQ: if (!granted) begin
          if (timed_out) error_r <= 1'b1;
          else           tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        S_HEADER: if (bus.slave_ready) begin
          hdr_sr   <= hdr_sr >> LANES;
          beat_cnt <= hdr_last ? '0 : beat_cnt + BEAT_W'(1);
        end
        S_WLOAD: if (bus.wr_valid) wr_sr <= bus.data_out;
        S_WDATA: if (bus.slave_ready) begin
          wr_sr <= wr_sr >> LANES;
          if (word_last) begin
            beat_cnt <= '0;
            word_cnt <= word_cnt + BURST_SIZE'(1);
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        S_RDATA: if (bus.slave_valid) begin
          rd_sr <= rd_word;
          if (word_last) begin
            beat_cnt  <= '0;
            word_cnt  <= word_cnt + BURST_SIZE'(1);
            data_in_r <= rd_word;
            new_rx_r  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_master_port.sv
// Bench for burst_master_port: drivers push expected beats/words/events into queues,
// a negedge monitor pops and compares whenever the port presents a beat, word or pulse.
module tb_burst_master_port;
  localparam int SL = 2, AL = 12, WS = 8, BS = 12, LN = 2, GT = 64;
  localparam int HDR_BEATS = 13;
  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  burst_master_port_if #(.SLAVE_LEN(SL), .ADDRESS_LEN(AL), .WORD_SIZE(WS),
                         .BURST_SIZE(BS), .LANES(LN)) bus ();

  burst_master_port #(.SLAVE_LEN(SL), .ADDRESS_LEN(AL), .WORD_SIZE(WS), .BURST_SIZE(BS),
                      .LANES(LN), .GRANT_TIMEOUT(GT))
    dut (.clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg));

  logic [3:0] beat_q[$];   // {tx_header, tx_data}
  logic [7:0] word_q[$];
  logic [3:0] evt_q[$];    // {error, rx_done, tx_done, trans_done}
  logic [7:0] wr_words[$];
  logic [1:0] rd_beats[$];

  int errors = 0, checks = 0;
  int cyc = 0, accept_cyc = 0, beat_idx = 0, events_seen = 0;
  int wr_ready_cycles = 0, hold_cnt = 0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_lanes = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with no expectation queued (cycle %0d)", name, cyc);
  endtask

  function automatic logic [23:0] outs();
    return {bus.cmd_ready, bus.wr_ready, bus.data_in, bus.new_rx, bus.tx_done, bus.rx_done,
            bus.trans_done, bus.error, bus.tx_header, bus.tx_data, bus.master_valid,
            bus.master_ready, bus.write_en, bus.read_en, bus.approval_request};
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [3:0] lanes;
    logic [3:0] code;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      lanes = {bus.tx_header, bus.tx_data};
      if (bus.cmd_valid && bus.cmd_ready) begin
        accept_cyc = cyc;
        beat_idx   = 0;
      end
      if (prev_stall) begin
        hold_cnt++;
        check("beat_hold", {bus.master_valid, lanes}, {1'b1, prev_lanes});
      end
      if (bus.master_valid && bus.slave_ready) begin
        if (beat_q.size() == 0) unexpected("beat");
        else check("beat", lanes, beat_q.pop_front());
        beat_idx++;
      end
      prev_stall = bus.master_valid && !bus.slave_ready;
      prev_lanes = lanes;
      if (bus.wr_ready) wr_ready_cycles++;
      if (bus.new_rx) begin
        if (word_q.size() == 0) unexpected("rx_word");
        else check("rx_word", bus.data_in, word_q.pop_front());
      end
      code = {bus.error, bus.rx_done, bus.tx_done, bus.trans_done};
      if (code != 4'b0000) begin
        events_seen++;
        if (evt_q.size() == 0) unexpected("event");
        else check("event", code, evt_q.pop_front());
        if (bus.error) begin
          check("error_latency", cyc - accept_cyc, GT + 1);
          check("error_idle", {bus.approval_request, bus.cmd_ready}, 2'b01);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.cmd_valid = 0; bus.instruction = 0; bus.slave_select = 0; bus.address = 0;
    bus.burst_num = 0; bus.data_out = 0; bus.wr_valid = 0; bus.rx_data = 0;
    bus.slave_ready = 0; bus.slave_valid = 0; bus.approval_grant = 0; bus.bus_busy = 0;
  endtask

  // Runs one command; wr_words / rd_beats / word_q are loaded by the caller beforehand.
  task automatic do_txn(input logic rd, input logic [1:0] slv, input logic [11:0] addr,
                        input logic [11:0] n, input logic grant, input int stall_beat,
                        input int stall_len, input int abort_beat);
    logic [25:0] hdr;
    logic [7:0] w;
    int start, stall_left;
    logic took_wr, took_rd, took_cmd, finished;
    hdr = {n, addr, slv};
    if (grant) begin
      for (int i = 0; i < HDR_BEATS; i++) beat_q.push_back({hdr[2*i +: 2], 2'b00});
      for (int k = 0; k < wr_words.size(); k++) begin
        w = wr_words[k];
        for (int j = 0; j < 4; j++) beat_q.push_back({2'b00, w[2*j +: 2]});
      end
      evt_q.push_back(rd ? 4'b0101 : 4'b0011);
    end else begin
      evt_q.push_back(4'b1000);
    end
    start = events_seen;
    stall_left = stall_len;
    finished = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.instruction = {1'b1, rd}; bus.slave_select = slv;
    bus.address = addr; bus.burst_num = n; bus.approval_grant = grant;
    for (int c = 0; c < BUDGET && !finished; c++) begin
      bus.slave_ready = 1;
      if (bus.master_valid && beat_idx == stall_beat && stall_left > 0) begin
        bus.slave_ready = 0;
        stall_left--;
      end
      bus.wr_valid    = (wr_words.size() > 0);
      bus.data_out    = bus.wr_valid ? wr_words[0] : 8'h00;
      bus.slave_valid = (rd_beats.size() > 0);
      bus.rx_data     = bus.slave_valid ? rd_beats[0] : 2'b00;
      @(negedge clk);
      took_wr  = bus.wr_valid && bus.wr_ready;
      took_rd  = bus.slave_valid && bus.master_ready;
      took_cmd = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (took_cmd) bus.cmd_valid = 0;
      if (took_wr) void'(wr_words.pop_front());
      if (took_rd) void'(rd_beats.pop_front());
      if (abort_beat > 0 && beat_idx >= abort_beat) begin
        reset = 1;
        beat_q.delete(); word_q.delete(); evt_q.delete(); wr_words.delete(); rd_beats.delete();
        finished = 1'b1;
      end
      if (events_seen != start) finished = 1'b1;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: no completion within %0d cycles", BUDGET);
    end
    idle_inputs();
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_beats_left"}, beat_q.size(), 0);
    check({name, "_words_left"}, word_q.size(), 0);
    check({name, "_events_left"}, evt_q.size(), 0);
  endtask

  initial begin
    int wr0, h0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_outputs", outs(), 24'h800000);
    check("reset_state", state_dbg, 0);

    // Write slave 1, addr 0A5, three words
    wr_words = '{8'h3C, 8'hA5, 8'hFF};
    do_txn(1'b0, 2'd1, 12'h0A5, 12'd3, 1'b1, -1, 0, 0);
    check_drained("write3");

    // Read one word: beats 01,11,00,10 assemble LSB-first to 8D
    rd_beats = '{2'b01, 2'b11, 2'b00, 2'b10};
    word_q.push_back(8'h8D);
    do_txn(1'b1, 2'd2, 12'h3C0, 12'd1, 1'b1, -1, 0, 0);
    check_drained("read1");
    check("data_in_hold", bus.data_in, 8'h8D);

    // slave_ready low for 5 cycles at header beat 4
    h0 = hold_cnt;
    wr_words = '{8'h5A};
    do_txn(1'b0, 2'd3, 12'hF0F, 12'd1, 1'b1, 4, 5, 0);
    check_drained("stall");
    check("stall_hold_cycles", hold_cnt - h0, 5);

    // Grant never given
    do_txn(1'b0, 2'd0, 12'h123, 12'd2, 1'b0, -1, 0, 0);
    check_drained("timeout");

    // Zero-length write: header only, no word requested
    wr0 = wr_ready_cycles;
    do_txn(1'b0, 2'd1, 12'h7FF, 12'd0, 1'b1, -1, 0, 0);
    check_drained("zero_burst");
    check("zero_burst_wr_ready", wr_ready_cycles - wr0, 0);

    // Two-word read: C6 = beats 10,01,00,11 ; 3F = beats 11,11,11,00
    rd_beats = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    word_q.push_back(8'hC6);
    word_q.push_back(8'h3F);
    do_txn(1'b1, 2'd0, 12'h001, 12'd2, 1'b1, -1, 0, 0);
    check_drained("read2");

    // Reset in the middle of the data phase of a write
    wr_words = '{8'h96, 8'h69};
    do_txn(1'b0, 2'd2, 12'h555, 12'd2, 1'b1, -1, 0, HDR_BEATS + 2);
    @(negedge clk);
    check("abort_outputs", outs(), 24'h800000);
    check("abort_state", state_dbg, 0);
    @(posedge clk); #1 reset = 0;

    // Recovery after abort
    wr_words = '{8'hE1};
    do_txn(1'b0, 2'd0, 12'h0F0, 12'd1, 1'b1, -1, 0, 0);
    check_drained("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
